// File: rtl/jk_ff.sv
// Bank of WIDTH independent positive-edge JK flip-flops with clock enable.
// q_n is the inverse of the single state register, so q and q_n always agree.
module jk_ff #(
  parameter int              WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n
);

  // JK characteristic equation, applied per bit: q+ = J&~q | ~K&q
  // (00 hold, 01 clear, 10 set, 11 toggle). Reset outranks enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (en) begin
      q <= (J & ~q) | (~K & q);
    end
  end

  assign q_n = ~q;

endmodule

// File: tb/tb_jk_ff.sv
// Directed self-checking bench for jk_ff: two 1-bit instances (reset values 0 and 1)
// and one 4-bit instance. Inputs change on falling edges; outputs are sampled 1 after rising edges.
module tb_jk_ff;

  logic       clk;
  logic       rst, en, j, k;
  logic       q, q_n, qr, qr_n;
  logic       rst4, en4;
  logic [3:0] j4, k4, q4, q4_n;

  int total = 0;
  int bad   = 0;

  jk_ff #(.WIDTH(1), .RESET_VAL(1'b0)) dut (
    .clk(clk), .rst(rst), .en(en), .J(j), .K(k), .q(q), .q_n(q_n)
  );

  jk_ff #(.WIDTH(1), .RESET_VAL(1'b1)) dut_rv1 (
    .clk(clk), .rst(rst), .en(en), .J(j), .K(k), .q(qr), .q_n(qr_n)
  );

  jk_ff #(.WIDTH(4), .RESET_VAL(4'b0000)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .J(j4), .K(k4), .q(q4), .q_n(q4_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive the 1-bit inputs on a falling edge, then sample after the next rising edge.
  task automatic apply1(input logic r, input logic e, input logic jv, input logic kv);
    @(negedge clk);
    rst = r; en = e; j = jv; k = kv;
    @(posedge clk);
    #1;
  endtask

  task automatic apply4(input logic r, input logic e, input logic [3:0] jv, input logic [3:0] kv);
    @(negedge clk);
    rst4 = r; en4 = e; j4 = jv; k4 = kv;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    apply1(1'b1, 1'b1, 1'b1, 1'b1);
    total++;
    if (q !== 1'b0) begin bad++; $display("[TB] FAIL reset_q: got %b want 0", q); end
    total++;
    if (q_n !== 1'b1) begin bad++; $display("[TB] FAIL reset_qn: got %b want 1", q_n); end
    total++;
    if (qr !== 1'b1) begin bad++; $display("[TB] FAIL reset_val1_q: got %b want 1", qr); end
    total++;
    if (qr_n !== 1'b0) begin bad++; $display("[TB] FAIL reset_val1_qn: got %b want 0", qr_n); end
  endtask

  task automatic test_truth_table;
    apply1(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (q !== 1'b1) begin bad++; $display("[TB] FAIL truth_set: got %b want 1", q); end
    for (int i = 0; i < 3; i++) begin
      apply1(1'b0, 1'b1, 1'b0, 1'b0);
      total++;
      if (q !== 1'b1) begin bad++; $display("[TB] FAIL truth_hold1[%0d]: got %b want 1", i, q); end
    end
    apply1(1'b0, 1'b1, 1'b0, 1'b1);
    total++;
    if (q !== 1'b0) begin bad++; $display("[TB] FAIL truth_clear: got %b want 0", q); end
    total++;
    if (q_n !== 1'b1) begin bad++; $display("[TB] FAIL truth_clear_qn: got %b want 1", q_n); end
    apply1(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (q !== 1'b0) begin bad++; $display("[TB] FAIL truth_hold0: got %b want 0", q); end
  endtask

  task automatic test_toggle;
    logic [3:0] want;
    want = 4'b0101;  // successive q after each toggle edge, bit 0 first: 1,0,1,0
    for (int i = 0; i < 4; i++) begin
      apply1(1'b0, 1'b1, 1'b1, 1'b1);
      total++;
      if (q !== want[i]) begin bad++; $display("[TB] FAIL toggle[%0d]: got %b want %b", i, q, want[i]); end
      total++;
      if (q_n !== ~want[i]) begin bad++; $display("[TB] FAIL toggle_qn[%0d]: got %b want %b", i, q_n, ~want[i]); end
    end
    apply1(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (q !== 1'b1) begin bad++; $display("[TB] FAIL toggle_set: got %b want 1", q); end
    apply1(1'b0, 1'b1, 1'b1, 1'b1);
    total++;
    if (q !== 1'b0) begin bad++; $display("[TB] FAIL toggle_from1: got %b want 0", q); end
    apply1(1'b0, 1'b1, 1'b0, 1'b0);
    total++;
    if (q !== 1'b0) begin bad++; $display("[TB] FAIL toggle_hold: got %b want 0", q); end
  endtask

  task automatic test_enable;
    apply1(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (q !== 1'b1) begin bad++; $display("[TB] FAIL enable_preset: got %b want 1", q); end
    for (int i = 0; i < 3; i++) begin
      apply1(1'b0, 1'b0, 1'b0, 1'b1);
      total++;
      if (q !== 1'b1) begin bad++; $display("[TB] FAIL enable_hold[%0d]: got %b want 1", i, q); end
    end
    apply1(1'b0, 1'b1, 1'b0, 1'b1);
    total++;
    if (q !== 1'b0) begin bad++; $display("[TB] FAIL enable_clear: got %b want 0", q); end
  endtask

  task automatic test_reset_priority;
    apply1(1'b0, 1'b1, 1'b1, 1'b0);
    total++;
    if (q !== 1'b1) begin bad++; $display("[TB] FAIL prio_preset: got %b want 1", q); end
    apply1(1'b1, 1'b1, 1'b1, 1'b0);
    total++;
    if (q !== 1'b0) begin bad++; $display("[TB] FAIL prio_reset_wins: got %b want 0", q); end
    total++;
    if (qr !== 1'b1) begin bad++; $display("[TB] FAIL prio_reset_val1: got %b want 1", qr); end
    apply1(1'b0, 1'b1, 1'b1, 1'b1);
    total++;
    if (q !== 1'b1) begin bad++; $display("[TB] FAIL prio_resume: got %b want 1", q); end
  endtask

  task automatic test_width4;
    apply4(1'b1, 1'b1, 4'b1111, 4'b1111);
    total++;
    if (q4 !== 4'b0000) begin bad++; $display("[TB] FAIL w4_reset: got %b want 0000", q4); end
    // bit3 set, bit2 clear, bit1 J=K=1 toggles 0->1, bit0 holds
    apply4(1'b0, 1'b1, 4'b1010, 4'b0110);
    total++;
    if (q4 !== 4'b1010) begin bad++; $display("[TB] FAIL w4_mixed: got %b want 1010", q4); end
    apply4(1'b0, 1'b1, 4'b1111, 4'b1111);
    total++;
    if (q4 !== 4'b0101) begin bad++; $display("[TB] FAIL w4_toggle: got %b want 0101", q4); end
    apply4(1'b0, 1'b1, 4'b0000, 4'b0000);
    total++;
    if (q4 !== 4'b0101) begin bad++; $display("[TB] FAIL w4_hold: got %b want 0101", q4); end
    total++;
    if (q4_n !== 4'b1010) begin bad++; $display("[TB] FAIL w4_qn: got %b want 1010", q4_n); end
    apply4(1'b0, 1'b0, 4'b1111, 4'b0000);
    total++;
    if (q4 !== 4'b0101) begin bad++; $display("[TB] FAIL w4_en_off: got %b want 0101", q4); end
    apply4(1'b0, 1'b1, 4'b1100, 4'b0011);
    total++;
    if (q4 !== 4'b1100) begin bad++; $display("[TB] FAIL w4_setclr: got %b want 1100", q4); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; j = 1'b0; k = 1'b0;
    rst4 = 1'b1; en4 = 1'b0; j4 = '0; k4 = '0;
    test_reset;
    test_truth_table;
    test_toggle;
    test_enable;
    test_reset_priority;
    test_width4;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
